// File: rtl/alu_seq_chunked.sv
// Multi-cycle add/sub/and/or ALU that processes CHUNK bits of a WIDTH-bit operation per clock.
// The slice carry is held in a register between slices, and valid/ready handshakes sit on both sides.
module alu_seq_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} op_t;

    state_t           r_state;
    state_t           w_state_next;
    op_t              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_co;
    logic             r_v;
    logic             r_z;
    logic             r_n;

    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK-1:0] w_bx;
    logic [CHUNK-1:0] w_res;
    logic [CHUNK:0]   w_sum;
    logic             w_arith;
    logic             w_c_msb;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = CALC;
            CALC:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Current slice: select operands, compute, and merge into the full result.
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_sl = r_a[k*CHUNK +: CHUNK];
                w_b_sl = r_b[k*CHUNK +: CHUNK];
            end
        end
        w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
        w_bx    = w_b_sl ^ {CHUNK{r_op == OP_SUB}};
        w_sum   = {1'b0, w_a_sl} + {1'b0, w_bx} + {{CHUNK{1'b0}}, r_carry};
        // Carry into the slice MSB, recovered from the sum bit and its two addend bits.
        w_c_msb = w_sum[CHUNK-1] ^ w_a_sl[CHUNK-1] ^ w_bx[CHUNK-1];
        case (r_op)
            OP_AND:  w_res = w_a_sl & w_b_sl;
            OP_OR:   w_res = w_a_sl | w_b_sl;
            default: w_res = w_sum[CHUNK-1:0];
        endcase
        w_s_next = r_s;
        for (int k = 0; k < NSLICE; k++) begin
            if (r_idx == IW'(k)) w_s_next[k*CHUNK +: CHUNK] = w_res;
        end
        w_last = (r_idx == IW'(NSLICE - 1));
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= op_t'(op);
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= (op == OP_SUB);
                        r_idx   <= '0;
                    end
                end
                CALC: begin
                    r_s   <= w_s_next;
                    r_idx <= r_idx + IW'(1);
                    if (w_arith) r_carry <= w_sum[CHUNK];
                    if (w_last) begin
                        r_co <= w_arith & w_sum[CHUNK];
                        r_v  <= w_arith & (w_c_msb ^ w_sum[CHUNK]);
                        r_z  <= (w_s_next == '0);
                        r_n  <= w_s_next[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign S  = r_s;
    assign Co = r_co;
    assign V  = r_v;
    assign Z  = r_z;
    assign N  = r_n;

endmodule

// File: tb/tb_alu_seq_chunked.sv
// Scoreboard bench for alu_seq_chunked: a 16/4 instance and an 8/8 single-slice instance.
// Drivers push hand-computed results; monitors pop and compare on each output handshake.
module tb_alu_seq_chunked;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef struct packed {
        logic [15:0] s;
        logic [3:0]  f;   // {Co, V, Z, N}
    } exp16_t;

    typedef struct packed {
        logic [7:0] s;
        logic [3:0] f;
    } exp8_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [1:0]  op = '0;
    logic [15:0] a = '0, b = '0, s;
    logic        co, v, z, n;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [1:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        co8, v8, z8, n8;

    exp16_t q16[$];
    exp8_t  q8[$];

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_chunked #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .S(s),
        .Co(co), .V(v), .Z(z), .N(n)
    );

    alu_seq_chunked #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .A(a8), .B(b8), .out_valid(out_valid8), .out_ready(out_ready8), .S(s8),
        .Co(co8), .V(v8), .Z(z8), .N(n8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : mon16
        exp16_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready) begin
                check("sb16_pending", 32'(q16.size() != 0), 1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("sb16_S", s, e.s);
                    check("sb16_flags", {co, v, z, n}, e.f);
                end
            end
        end
    end

    initial begin : mon8
        exp8_t e;
        forever begin
            @(negedge clk);
            if (out_valid8 === 1'b1 && out_ready8) begin
                check("sb8_pending", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check("sb8_S", s8, e.s);
                    check("sb8_flags", {co8, v8, z8, n8}, e.f);
                end
            end
        end
    end

    task automatic run16(input logic [1:0] o, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] es, input logic [3:0] ef);
        int t;
        exp16_t e;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready16_wait", in_ready, 1);
        in_valid = 1'b1; op = o; a = ia; b = ib;
        e.s = es; e.f = ef;
        q16.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1 t++;
        end
        check("latency16", t, 4);
        if (out_ready) begin
            @(posedge clk);
            #1 check("out_valid16_one_cycle", out_valid, 0);
        end
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] es, input logic [3:0] ef);
        int t;
        exp8_t e;
        @(negedge clk);
        t = 0;
        while (!in_ready8 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready8_wait", in_ready8, 1);
        in_valid8 = 1'b1; op8 = o; a8 = ia; b8 = ib;
        e.s = es; e.f = ef;
        q8.push_back(e);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        t = 0;
        while (!out_valid8 && t < 50) begin
            @(posedge clk);
            #1 t++;
        end
        check("latency8", t, 1);
        @(posedge clk);
        #1 check("out_valid8_one_cycle", out_valid8, 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int seen;
        // Reset with in_valid held high: nothing may be accepted.
        #1 rst = 1'b1;
        in_valid = 1'b1; in_valid8 = 1'b1;
        #1;
        check("rst_S", s, 16'h0000);
        check("rst_flags", {co, v, z, n}, 4'b0000);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_S8", s8, 8'h00);
        repeat (3) @(negedge clk);
        in_valid = 1'b0; in_valid8 = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 check("post_rst_in_ready", in_ready, 1);

        // Basic arithmetic, including carries across every slice boundary.
        run16(OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 4'b0000);
        run16(OP_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b1010);
        run16(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0001);
        run16(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        run16(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
        run16(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100);

        // Backpressure: result held, new requests refused.
        out_ready = 1'b0;
        run16(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0); op = OP_OR; a = 16'hFFFF; b = 16'h0000;
            @(negedge clk);
            check("bp_S", s, 16'h3030);
            check("bp_flags", {co, v, z, n}, 4'b0000);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        run16(OP_OR, 16'h1200, 16'h0034, 16'h1234, 4'b0000);

        // Abort after two slices of an add.
        @(negedge clk);
        in_valid = 1'b1; op = OP_ADD; a = 16'h1234; b = 16'h1111;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_S", s, 16'h0000);
        check("abort_flags", {co, v, z, n}, 4'b0000);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_out_valid", seen, 0);
        run16(OP_ADD, 16'h1234, 16'h1111, 16'h2345, 4'b0000);

        // Single-slice instance.
        run8(OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        run8(OP_OR,  8'h00, 8'h00, 8'h00, 4'b0010);
        run8(OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010);

        repeat (3) @(negedge clk);
        check("sb16_drained", q16.size(), 0);
        check("sb8_drained", q8.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
